// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU run/step sequencer: state encoding and its width.
package cpu_clk_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// CPU-facing bundle of the run/step sequencer: halt request in, clock/enable/status out.
import cpu_clk_pkg::*;

interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic               cpu_halt;
  logic               cpu_clk;
  logic               cpu_ce;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cycle_cnt;
  logic               limit_hit;

  modport master (
    input  cpu_halt,
    output cpu_clk, cpu_ce, state, cycle_cnt, limit_hit
  );

  modport slave (
    output cpu_halt,
    input  cpu_clk, cpu_ce, state, cycle_cnt, limit_hit
  );
endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// rising-edge detector; a held button yields a single one-clock pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = btn;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer producing a divided CPU clock and a one-clock CPU enable.
// Optional forced halt after CYCLE_LIMIT CPU cycles when CYCLE_LIMIT_EN is defined.
module cpu_run_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_LOG2    = 2,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_btn,
  input  logic                  step_btn,
  cpu_run_ctrl_if.master        bus
);

  localparam logic [DIV_LOG2-1:0] PHASE_LAST = '1;

  logic                run_p;
  logic                step_p;
  state_e              state_q, state_d;
  logic [DIV_LOG2-1:0] phase_q, phase_d;
  logic                ce_q, ce_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_done;

`ifdef CYCLE_LIMIT_EN
  logic limit_q, limit_d;
`else
  logic unused_cycle_limit;
  assign unused_cycle_limit = ^CYCLE_LIMIT;
`endif

  btn_edge_sync u_run_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (run_btn),
    .pulse (run_p)
  );

  btn_edge_sync u_step_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_p)
  );

  assign phase_done = (phase_q == PHASE_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = '0;
    ce_d    = 1'b0;
    cnt_d   = cnt_q;
`ifdef CYCLE_LIMIT_EN
    limit_d = limit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run_p) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // Halt outranks pause, and pause drops the partial CPU cycle without a ce.
        if (bus.cpu_halt) begin
          state_d = ST_HALTED;
        end else if (run_p) begin
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + DIV_LOG2'(1);
          ce_d    = phase_done;
        end
      end
      ST_STEP: begin
        if (bus.cpu_halt) begin
          state_d = ST_HALTED;
        end else if (phase_done) begin
          ce_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + DIV_LOG2'(1);
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase

    if (ce_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

`ifdef CYCLE_LIMIT_EN
    if (ce_d && (cnt_d == CNT_W'(CYCLE_LIMIT))) begin
      state_d = ST_HALTED;
      phase_d = '0;
      limit_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      ce_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef CYCLE_LIMIT_EN
      limit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ce_q    <= ce_d;
      cnt_q   <= cnt_d;
`ifdef CYCLE_LIMIT_EN
      limit_q <= limit_d;
`endif
    end
  end

  assign bus.cpu_clk   = phase_q[DIV_LOG2-1];
  assign bus.cpu_ce    = ce_q;
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cnt_q;
`ifdef CYCLE_LIMIT_EN
  assign bus.limit_hit = limit_q;
`else
  assign bus.limit_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (DIV_LOG2=2, CNT_W=32, CYCLE_LIMIT=5).
module tb_cpu_run_ctrl;

  logic clk;
  logic reset;
  logic run_btn;
  logic step_btn;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl_if #(.CNT_W(32)) bus ();

  cpu_run_ctrl #(
    .DIV_LOG2    (2),
    .CNT_W       (32),
    .CYCLE_LIMIT (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_btn  (run_btn),
    .step_btn (step_btn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic ce,
                         input logic cclk, input logic [31:0] cnt, input logic lim);
    chk({tag, "_state"}, 32'(bus.state), 32'(st));
    chk({tag, "_ce"}, 32'(bus.cpu_ce), 32'(ce));
    chk({tag, "_cpuclk"}, 32'(bus.cpu_clk), 32'(cclk));
    chk({tag, "_cnt"}, bus.cycle_cnt, cnt);
    chk({tag, "_limit"}, 32'(bus.limit_hit), 32'(lim));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Button raised right after an edge: pulse after the 3rd edge, state change at the 4th.
  task automatic press(input logic r, input logic s, input logic [1:0] st_before,
                       input logic [1:0] st_after, input string tag);
    run_btn  = r;
    step_btn = s;
    repeat (3) tick();
    chk({tag, "_pre"}, 32'(bus.state), 32'(st_before));
    tick();
    chk({tag, "_post"}, 32'(bus.state), 32'(st_after));
    run_btn  = 1'b0;
    step_btn = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    run_btn      = 1'b0;
    step_btn     = 1'b0;
    bus.cpu_halt = 1'b0;

    // Reset state
    do_reset();
    chk_all("rst", 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);

    // 1: free run, ce every 4 clks, cpu_clk 50% duty
    press(1'b1, 1'b0, 2'd0, 2'd1, "t1_run");
    chk_all("t1_entry", 2'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all($sformatf("t1_k%0d", k), 2'd1, (k % 4) == 0, (k % 4) >= 2, 32'(k / 4), 1'b0);
    end

    // 2: two single steps
    do_reset();
    for (int s = 0; s < 2; s++) begin
      press(1'b0, 1'b1, 2'd0, 2'd2, $sformatf("t2_step%0d", s));
      for (int k = 1; k <= 4; k++) begin
        tick();
        chk_all($sformatf("t2_s%0d_k%0d", s, k), (k < 4) ? 2'd2 : 2'd0, k == 4,
                (k >= 2) && (k < 4), 32'(s + ((k == 4) ? 1 : 0)), 1'b0);
      end
      for (int k = 0; k < 6; k++) begin
        tick();
        chk($sformatf("t2_s%0d_idle_ce%0d", s, k), 32'(bus.cpu_ce), 32'd0);
      end
    end
    chk("t2_cnt", bus.cycle_cnt, 32'd2);
    chk("t2_state", 32'(bus.state), 32'd0);

    // 3: pause with run_p seen while phase==2
    do_reset();
    press(1'b1, 1'b0, 2'd0, 2'd1, "t3_run");
    repeat (3) tick();
    run_btn = 1'b1;
    tick();
    chk_all("t3_ce1", 2'd1, 1'b1, 1'b0, 32'd1, 1'b0);
    tick();
    tick();
    chk_all("t3_ph2", 2'd1, 1'b0, 1'b1, 32'd1, 1'b0);
    tick();
    chk_all("t3_pause", 2'd0, 1'b0, 1'b0, 32'd1, 1'b0);
    run_btn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all($sformatf("t3_idle%0d", k), 2'd0, 1'b0, 1'b0, 32'd1, 1'b0);
    end

    // 4: halt while a ce is already on the output; buttons then ignored
    do_reset();
    press(1'b1, 1'b0, 2'd0, 2'd1, "t4_run");
    repeat (4) tick();
    chk_all("t4_ce1", 2'd1, 1'b1, 1'b0, 32'd1, 1'b0);
    bus.cpu_halt = 1'b1;
    tick();
    chk_all("t4_halt", 2'd3, 1'b0, 1'b0, 32'd1, 1'b0);
    bus.cpu_halt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all($sformatf("t4_held%0d", k), 2'd3, 1'b0, 1'b0, 32'd1, 1'b0);
    end
    press(1'b1, 1'b0, 2'd3, 2'd3, "t4_runbtn");
    tick();
    press(1'b0, 1'b1, 2'd3, 2'd3, "t4_stepbtn");
    repeat (3) tick();
    chk_all("t4_still", 2'd3, 1'b0, 1'b0, 32'd1, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_all("t4_rst", 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);

    // 5: simultaneous run+step -> RUN; step in RUN ignored
    do_reset();
    press(1'b1, 1'b1, 2'd0, 2'd1, "t5_both");
    tick();
    chk_all("t5_k1", 2'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    step_btn = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk_all($sformatf("t5_k%0d", k), 2'd1, (k % 4) == 0, (k % 4) >= 2, 32'(k / 4), 1'b0);
    end
    step_btn = 1'b0;

    // 6: cycle limit of 5
    do_reset();
    press(1'b1, 1'b0, 2'd0, 2'd1, "t6_run");
    repeat (20) tick();
`ifdef CYCLE_LIMIT_EN
    chk_all("t6_limit", 2'd3, 1'b1, 1'b0, 32'd5, 1'b1);
    repeat (4) tick();
    chk_all("t6_after", 2'd3, 1'b0, 1'b0, 32'd5, 1'b1);
`else
    chk_all("t6_ce5", 2'd1, 1'b1, 1'b0, 32'd5, 1'b0);
    repeat (4) tick();
    chk_all("t6_ce6", 2'd1, 1'b1, 1'b0, 32'd6, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
